// File: rtl/ts_sel_pkg.sv
// rtl/ts_sel_pkg.sv - shared state type, constants and vector slice helper for ts_channel_selector
package ts_sel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_AUTO,
    ST_EVAL,
    ST_DECIDE,
    ST_MANUAL
  } sel_state_t;

  localparam logic        MODE_AUTO      = 1'b0;
  localparam logic        MODE_MANUAL    = 1'b1;
  localparam logic [15:0] SWITCH_CNT_MAX = 16'hFFFF;
  localparam int          VEC_MAX        = 1024;

  // Field idx of width w (w <= 32) from a packed per-channel vector, zero-extended.
  function automatic logic [31:0] vec_slice(input logic [VEC_MAX-1:0] vec,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [VEC_MAX-1:0] shifted;
    shifted = vec >> (idx * w);
    return shifted[31:0] & ~(32'hFFFF_FFFF << w);
  endfunction

endpackage

// File: rtl/ts_presence_tracker.sv
// rtl/ts_presence_tracker.sv - evaluation window counter, sticky per-channel presence and window snapshot
module ts_presence_tracker #(
  parameter int NUM_CH  = 4,
  parameter int TIMER_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run,
  input  logic [TIMER_W-1:0] window,
  input  logic [NUM_CH-1:0]  valid,
  output logic               window_done,
  output logic [NUM_CH-1:0]  present_snap
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] win_last;
  logic [NUM_CH-1:0]  sticky_q;

  // A zero-length window behaves as a one-cycle window.
  assign win_last    = (window == '0) ? '0 : window - 1'b1;
  assign window_done = run && (count_q == win_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      sticky_q     <= '0;
      present_snap <= '0;
    end else begin
      if (clear || window_done) begin
        count_q <= '0;
      end else if (run) begin
        count_q <= count_q + 1'b1;
      end
      // valid on the clearing cycle still lands in the fresh window
      sticky_q <= ((clear || window_done) ? '0 : sticky_q) | valid;
      if (window_done) begin
        present_snap <= sticky_q;
      end
    end
  end

endmodule

// File: rtl/ts_channel_selector.sv
// rtl/ts_channel_selector.sv - manual/auto TS input channel selector with windowed priority scan
// Optional saturating switch counter built when TS_SEL_SWITCH_STATS_EN is defined.
module ts_channel_selector
  import ts_sel_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int CNT_W   = 8,
  parameter int TIMER_W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      valid,
  input  logic [NUM_CH*CNT_W-1:0] err_count,
  input  logic                   cfg_write,
  input  logic                   cfg_manual_en,
  input  logic [CH_W-1:0]        cfg_manual_ch,
  input  logic [NUM_CH*CH_W-1:0] cfg_priority,
  input  logic [TIMER_W-1:0]     cfg_window,
  input  logic [CNT_W-1:0]       cfg_hysteresis,
  input  logic                   cfg_fallback_en,
  output logic [CH_W-1:0]        mux_sel,
  output logic                   mux_en,
  output logic                   cnt_clear,
  output logic                   switch_pulse,
  output logic [NUM_CH-1:0]      signal_present,
  output logic [15:0]            switch_count
);

  sel_state_t state_q, state_d;

  logic                    sh_manual_en;
  logic [CH_W-1:0]         sh_manual_ch;
  logic [NUM_CH*CH_W-1:0]  sh_priority;
  logic [TIMER_W-1:0]      sh_window;
  logic [CNT_W-1:0]        sh_hyst;
  logic                    sh_fallback;

  logic [NUM_CH*CNT_W-1:0] err_snap;
  logic [CH_W-1:0]         idx;
  logic [CH_W-1:0]         best_ch;
  logic [CH_W-1:0]         best_pos;
  logic [CH_W-1:0]         cur_pos;
  logic [CNT_W-1:0]        best_err;
  logic                    best_valid;
  logic                    cur_found;
  logic                    window_done;

  logic [CH_W-1:0]         prio_first;
  logic [CH_W-1:0]         eval_ch;
  logic [CNT_W-1:0]        eval_err;
  logic [CNT_W-1:0]        cur_err;
  logic                    cur_present;
  logic [CNT_W:0]          best_margin;
  logic                    best_first;
  logic                    do_switch;
  logic                    switch_now;

  ts_presence_tracker #(
    .NUM_CH  (NUM_CH),
    .TIMER_W (TIMER_W)
  ) u_presence (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state_q == ST_CONFIG),
    .run          (state_q == ST_AUTO),
    .window       (sh_window),
    .valid        (valid),
    .window_done  (window_done),
    .present_snap (signal_present)
  );

  assign prio_first  = CH_W'(vec_slice(VEC_MAX'(sh_priority), 0, CH_W));
  assign eval_ch     = CH_W'(vec_slice(VEC_MAX'(sh_priority), 32'(idx), CH_W));
  assign eval_err    = CNT_W'(vec_slice(VEC_MAX'(err_snap), 32'(eval_ch), CNT_W));
  assign cur_err     = CNT_W'(vec_slice(VEC_MAX'(err_snap), 32'(mux_sel), CNT_W));
  assign cur_present = signal_present[mux_sel];

  // One extra bit so best_err + hysteresis never wraps below cur_err.
  assign best_margin = {1'b0, best_err} + {1'b0, sh_hyst};
  assign best_first  = !cur_found || (best_pos < cur_pos);
  assign do_switch   = best_valid &&
                       (!cur_present ||
                        ((best_ch != mux_sel) && (best_margin < {1'b0, cur_err})) ||
                        (sh_fallback && (best_margin <= {1'b0, cur_err}) && best_first));
  assign switch_now  = (state_q == ST_DECIDE) && !cfg_write && do_switch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_write) begin
      state_d = ST_CONFIG;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_CONFIG: state_d = (sh_manual_en == MODE_MANUAL) ? ST_MANUAL : ST_AUTO;
        ST_AUTO:   if (window_done) state_d = ST_EVAL;
        ST_EVAL:   if (idx == CH_W'(NUM_CH - 1)) state_d = ST_DECIDE;
        ST_DECIDE: state_d = ST_AUTO;
        ST_MANUAL: state_d = ST_MANUAL;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_manual_en <= 1'b0;
      sh_manual_ch <= '0;
      sh_priority  <= '0;
      sh_window    <= '0;
      sh_hyst      <= '0;
      sh_fallback  <= 1'b0;
      err_snap     <= '0;
      idx          <= '0;
      best_ch      <= '0;
      best_pos     <= '0;
      cur_pos      <= '0;
      best_err     <= '0;
      best_valid   <= 1'b0;
      cur_found    <= 1'b0;
      mux_sel      <= '0;
      mux_en       <= 1'b0;
      cnt_clear    <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      cnt_clear    <= 1'b0;
      switch_pulse <= 1'b0;
      if (cfg_write) begin
        sh_manual_en <= cfg_manual_en;
        sh_manual_ch <= cfg_manual_ch;
        sh_priority  <= cfg_priority;
        sh_window    <= cfg_window;
        sh_hyst      <= cfg_hysteresis;
        sh_fallback  <= cfg_fallback_en;
      end
      case (state_q)
        ST_CONFIG: begin
          mux_en    <= 1'b1;
          cnt_clear <= 1'b1;
          mux_sel   <= (sh_manual_en == MODE_AUTO) ? prio_first : sh_manual_ch;
        end
        ST_AUTO: begin
          if (window_done) begin
            err_snap   <= err_count;
            idx        <= '0;
            best_valid <= 1'b0;
            cur_found  <= 1'b0;
          end
        end
        ST_EVAL: begin
          // Strict compare keeps the earlier priority entry on equal error counts.
          if (signal_present[eval_ch] && (!best_valid || (eval_err < best_err))) begin
            best_valid <= 1'b1;
            best_ch    <= eval_ch;
            best_err   <= eval_err;
            best_pos   <= idx;
          end
          if ((eval_ch == mux_sel) && !cur_found) begin
            cur_found <= 1'b1;
            cur_pos   <= idx;
          end
          idx <= idx + 1'b1;
        end
        ST_DECIDE: begin
          if (!cfg_write) begin
            cnt_clear <= 1'b1;
          end
          if (switch_now) begin
            mux_sel      <= best_ch;
            switch_pulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TS_SEL_SWITCH_STATS_EN
  logic [15:0] sw_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_q <= '0;
    end else if (switch_now && (sw_cnt_q != SWITCH_CNT_MAX)) begin
      sw_cnt_q <= sw_cnt_q + 16'd1;
    end
  end

  assign switch_count = sw_cnt_q;
`else
  assign switch_count = 16'h0000;
`endif

endmodule

// File: doc/ts_channel_selector.md
Name: ts_channel_selector

Overview:
- Parametrised successor to the 4-channel MPEG2-TS input controller.
- Picks one of NUM_CH transport-stream inputs for the output mux, in manual or automatic mode.
- Auto mode: per-channel presence and error counts are collected over a programmable window, then a sequential priority scan selects the best channel, with switch hysteresis and fallback-to-priority.
- Sits between the per-channel continuity/error counters and the TS output mux; configuration comes from the register block as a latched config bundle.

Parameters:
- NUM_CH, 4, number of TS input channels (>=2).
- CH_W, $clog2(NUM_CH), channel index width.
- CNT_W, 8, per-channel error-count width.
- TIMER_W, 20, evaluation-window counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  NUM_CH  per-channel packet-valid strobe; bit i = channel i.
- err_count  in  NUM_CH*CNT_W  per-channel error counts; channel i at [i*CNT_W +: CNT_W].
- cfg_write  in  1  one-cycle pulse: apply the cfg_* bundle.
- cfg_manual_en  in  1  1 = manual mode.
- cfg_manual_ch  in  CH_W  channel used in manual mode.
- cfg_priority  in  NUM_CH*CH_W  priority list; entry 0 at [CH_W-1:0] is the highest priority.
- cfg_window  in  TIMER_W  window length in cycles; 0 is treated as 1.
- cfg_hysteresis  in  CNT_W  required error margin before switching.
- cfg_fallback_en  in  1  on ties, return to the higher-priority channel.
- mux_sel  out  CH_W  selected channel.
- mux_en  out  1  mux enable.
- cnt_clear  out  1  one-cycle pulse that clears the external error counters.
- switch_pulse  out  1  one-cycle pulse on every auto-mode switch.
- signal_present  out  NUM_CH  presence snapshot from the last completed window.
- switch_count  out  16  saturating auto-switch counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; mux_sel=0, mux_en=0, cnt_clear=0, switch_pulse=0, signal_present=0, switch_count=0; window counter, sticky presence and shadow config all cleared.
- States: IDLE, CONFIG, AUTO, EVAL, DECIDE, MANUAL.
- cfg_write in any state: next state CONFIG; this takes priority over every other transition and aborts EVAL/DECIDE with no switch_pulse.
- IDLE: waits for cfg_write.
- CONFIG (1 cycle):
  - latch the cfg_* bundle into shadow registers;
  - mux_en<=1; cnt_clear pulses; sticky presence and window counter cleared;
  - manual: mux_sel<=cfg_manual_ch, go MANUAL;
  - auto: mux_sel<=priority entry 0, go AUTO.
- MANUAL: mux_sel is held; valid and err_count are ignored except for presence tracking.
- Presence tracking: registered sticky bits, set by valid[i]; cleared in CONFIG and at each window end. The set wins if valid[i] arrives on the clear cycle.
- AUTO: window counter increments each cycle. When counter == max(window,1)-1:
  - snapshot sticky presence into signal_present;
  - snapshot err_count;
  - clear sticky presence and the counter;
  - go EVAL.
- EVAL: NUM_CH cycles, idx = 0..NUM_CH-1, one priority entry per cycle.
  - An entry is skipped if its channel is not present.
  - best is updated if no best yet, or err < best_err (strict compare, so the earlier priority wins ties).
  - Duplicate list entries are legal and harmless.
- DECIDE (1 cycle), then AUTO. Compare err_best+hyst against err_cur in CNT_W+1 bits, with no wrap. Rules, first match wins:
  1. No channel present: keep mux_sel.
  2. Current channel not present: switch to best.
  3. best != cur and err_best+hyst < err_cur: switch.
  4. cfg_fallback_en and err_best+hyst <= err_cur and best precedes cur in the priority list: switch.
  5. Otherwise: keep.
- A switch updates mux_sel and pulses switch_pulse. cnt_clear pulses in every DECIDE.
- Effective auto period is window+NUM_CH+1 cycles.
- Outputs are registered; mux_sel changes the cycle after DECIDE's clock edge.

Optional Feature:
- Macro: TS_SEL_SWITCH_STATS_EN.
- Defined: switch_count increments on every switch_pulse, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: no counter logic is built; switch_count is tied to 0.

Decomposition:
- Package ts_sel_pkg holds:
  - state enum (IDLE..MANUAL);
  - mode constants;
  - a slice function for the err/priority vectors;
  - a saturation limit constant.
- One sub-module, ts_presence_tracker: the window counter, the sticky valid bits and the snapshot. It outputs window_done and present_snap.

Test Plan (NUM_CH=4, CNT_W=8):
1. Manual mode: cfg_write with manual_en=1, manual_ch=2 -> two cycles later mux_sel=2 and mux_en=1; mux_sel stays 2 while valid and err toggle for 1000 cycles.
2. Basic auto switch: prio {0,1,2,3}, window=16, all valid, err {10,5,5,20}, hyst=0 -> after 16+5 cycles mux_sel=1 (ch1 beats ch2 on the tie) and one switch_pulse.
3. Hysteresis: hyst=8, cur=0 with err 10, ch1 err 5 -> no switch. Then cur err 20 -> switch to 1.
4. Channel lost: cur ch0 has no valid in the window, ch3 present with err 200 and the others absent -> mux_sel=3. All channels absent -> mux_sel unchanged, cnt_clear still pulses.
5. Fallback tie: cur=2, ch0 err equals ch2 err, hyst=0. fallback_en=1 -> mux_sel=0; fallback_en=0 -> stays 2.
6. Abort and reset: cfg_write mid-EVAL -> CONFIG next cycle with no switch_pulse. rst_n low mid-EVAL -> all outputs return to reset values asynchronously.
